// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer FSM states and mode bit positions.
package spi_pkg;

  // mode[CPOL_BIT] is the idle sclk level. mode[CPHA_BIT]=0 samples on the leading edge and
  // shifts on the trailing edge; mode[CPHA_BIT]=1 shifts on the leading edge and samples on the
  // trailing edge. Modes 0..3 map to {CPOL,CPHA} = 00, 01, 10, 11.
  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// sclk edge timer: a half-period divider plus an edge counter, cleared whenever disabled.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DATA_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic lead_stb,
  output logic trail_stb,
  output logic last_edge,
  output logic hold_done
);

  localparam int unsigned NumEdges = 2 * DATA_W;
  localparam int unsigned DivW     = $clog2(CLK_DIV + 1);
  localparam int unsigned EdgeW    = $clog2(2 * DATA_W + 1);

  logic [DivW-1:0]  div_q;
  logic [EdgeW-1:0] edge_q;
  logic             tick;
  logic             in_shift;

  // The first tick ends SETUP; ticks 1..NumEdges are sclk edges, the next one ends HOLD.
  assign tick      = en && (div_q == DivW'(CLK_DIV - 1));
  assign in_shift  = edge_q < EdgeW'(NumEdges);
  assign lead_stb  = tick && in_shift && !edge_q[0];
  assign trail_stb = tick && in_shift && edge_q[0];
  assign last_edge = tick && (edge_q == EdgeW'(NumEdges - 1));
  assign hold_done = tick && (edge_q == EdgeW'(NumEdges));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      edge_q <= '0;
    end else if (!en) begin
      div_q  <= '0;
      edge_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        edge_q <= edge_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_xfer.sv
// SPI master transfer engine: one word per handshake, all four CPOL/CPHA modes, MSB first.
module spi_master_xfer
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  spi_state_e        state_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              lead_stb;
  logic              trail_stb;
  logic              last_edge;
  logic              hold_done;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV),
    .DATA_W (DATA_W)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q != StIdle),
    .lead_stb (lead_stb),
    .trail_stb(trail_stb),
    .last_edge(last_edge),
    .hold_done(hold_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      ss_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sclk <= mode[CPOL_BIT];
          if (tx_valid && tx_ready) begin
            tx_sh    <= tx_data;
            rx_sh    <= '0;
            mode_q   <= mode;
            ss_n     <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StSetup;
            // CPHA=0 must present the MSB a full half-period before the first sample edge.
            if (!mode[CPHA_BIT]) begin
              mosi <= tx_data[DATA_W-1];
            end
          end
        end
        StSetup: if (lead_stb) state_q <= StShift;
        StShift: if (last_edge) state_q <= StHold;
        StHold: begin
          if (hold_done) begin
            state_q  <= StIdle;
            sclk     <= mode_q[CPOL_BIT];
            ss_n     <= 1'b1;
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (lead_stb || trail_stb) begin
        sclk <= ~sclk;
      end
      if (mode_q[CPHA_BIT]) begin
        if (lead_stb) begin
          mosi  <= tx_sh[DATA_W-1];
          tx_sh <= tx_sh << 1;
        end
        if (trail_stb) begin
          rx_sh <= {rx_sh[DATA_W-2:0], miso};
        end
      end else begin
        if (lead_stb) begin
          rx_sh <= {rx_sh[DATA_W-2:0], miso};
        end
        // The MSB went out at SETUP, so the final trailing edge has nothing left to shift.
        if (trail_stb && !last_edge) begin
          mosi  <= tx_sh[DATA_W-2];
          tx_sh <= tx_sh << 1;
        end
      end
    end
  end

endmodule
